wb_watch_tracer: RTL and testbench
==================================

Name: wb_watch_tracer

Overview:
- Synthesizable, parametrised writeback trace unit attached to the core's WB-stage outputs (reg-write enable, rd address, write data).
- Replaces single-register ad-hoc tracing with NUM_WATCH programmable watch slots.
- Each slot has its own mode: log, log-and-compare against an expected value, or one-shot.
- Matching writes are timestamped and queued in a DEPTH-entry FIFO drained by a valid/ready consumer. Overflow and mismatch status are kept as sticky counters and flags.

Parameters:
- NUM_WATCH, 4, number of watch slots (1..8)
- DEPTH, 16, event FIFO entries (power of 2, >=2)
- XLEN, 32, register data width
- CYC_W, 32, timestamp counter width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- wb_reg_write  in  1  WB stage writing the register file this cycle
- wb_rd_addr  in  5  WB destination register
- wb_write_data  in  XLEN  WB write data
- cfg_we  in  1  write slot cfg_idx
- cfg_idx  in  max(1,$clog2(NUM_WATCH))  slot select
- cfg_addr  in  5  register watched by slot
- cfg_mode  in  2  00 off, 01 log, 10 log+compare, 11 one-shot log
- cfg_expect  in  XLEN  expected value (mode 10)
- clear  in  1  sync clear of FIFO, counters and sticky flags; config retained
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_slot  out  max(1,$clog2(NUM_WATCH))  matching slot
- evt_rd  out  5  register written
- evt_data  out  XLEN  value written
- evt_cycle  out  CYC_W  timestamp of the write
- evt_mismatch  out  1  compare failed (mode 10 only)
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- overflow_cnt  out  16  dropped events, saturating
- mismatch_flag  out  1  sticky: any mismatch seen

Behaviour:
- Reset (reset=0, asynchronous):
  - All slots: mode 00, addr 0, expect 0, armed 1.
  - FIFO empty; cycle counter 0.
  - All outputs 0.
- Cycle counter:
  - Increments every cycle out of reset and wraps at 2^CYC_W.
  - clear resets it to 0.
  - A write's timestamp is the counter value in the cycle wb_reg_write is sampled.
- Match in cycle t:
  - Conditions: wb_reg_write=1, wb_rd_addr!=0, slot mode!=00, slot addr==wb_rd_addr, and for mode 11 the slot is armed.
  - Matching is evaluated against the config registered before t. A cfg_we in cycle t takes effect at t+1.
  - Several slots matching: lowest index wins. At most one event per cycle.
- Event contents: slot, rd, data, timestamp, and mismatch = (mode==10 && data!=expect). Mismatch also sets mismatch_flag.
- One-shot (mode 11): a logged event clears the slot's armed bit. Any cfg_we to that slot sets armed=1.
- FIFO behaviour:
  - First-word-fall-through. An event matched in cycle t is visible on evt_* at t+1 if the FIFO was empty (latency 1).
  - Outputs hold stable while evt_valid=1 and evt_ready=0.
  - Pop when evt_valid && evt_ready.
  - Pointers wrap modulo DEPTH.
- Full handling:
  - Push while full without a same-cycle pop: event dropped; overflow_cnt+1, saturating at 0xFFFF.
  - Push and pop in the same cycle while full: push accepted, count unchanged.
  - A dropped one-shot event still disarms the slot.
  - A dropped compare event still sets mismatch_flag.
- clear:
  - Takes priority over push and pop in the same cycle; the incoming event is discarded and not counted.
  - Resets FIFO, fifo_count, overflow_cnt, mismatch_flag and the cycle counter.
  - Slot config and armed bits are unchanged.
- Reset mid-operation: immediate return to reset state; in-flight FIFO contents lost.

Test Plan:
- Slot0 log x5, single write x5=0x0000000A at cycle 7 -> next cycle evt_valid=1, evt_rd=5, evt_data=0x0A, evt_cycle=7, evt_slot=0, fifo_count=1; pop -> fifo_count=0, evt_valid=0.
- Slot1 mode 10 on x6, expect 0x14; writes x6=0x14 then x6=0x15 -> two events, evt_mismatch 0 then 1; mismatch_flag=1 and stays 1 until clear.
- Slot0 and slot2 both watch x7, slot2 one-shot; write x7 three times -> three events, all evt_slot=0. Disable slot0, rewrite slot2 (re-arms), write x7 twice -> one event, evt_slot=2.
- DEPTH=16, evt_ready=0, 20 matching writes -> fifo_count=16, overflow_cnt=4, head still holds first event. Then full with push+pop in the same cycle -> fifo_count stays 16, overflow_cnt stays 4.
- Write to x0 with slot addr 0 and mode 01 -> no event. cfg_we retargeting slot0 x5->x8 in the same cycle as an x5 write -> x5 event logged; an x8 write next cycle is also logged.
- 3 events queued, assert clear with a matching write in the same cycle -> fifo_count=0, overflow_cnt=0, no event. Drop reset mid-stream -> all outputs 0 asynchronously, slots disabled.

Source files
------------

// File: rtl/wb_watch_tracer.sv
// Writeback trace unit. Watches the WB-stage register-file write port and
// compares it against NUM_WATCH programmable slots. Each matching write
// becomes a timestamped event in a first-word-fall-through FIFO. The FIFO is
// drained through a valid/ready handshake. Dropped events and compare
// mismatches are kept in sticky status registers.
module wb_watch_tracer #(
  parameter  int NUM_WATCH = 4,
  parameter  int DEPTH     = 16,
  parameter  int XLEN      = 32,
  parameter  int CYC_W     = 32,
  localparam int IDX_W     = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int CNT_W     = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd_addr,
  input  logic [XLEN-1:0]  wb_write_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [4:0]       cfg_addr,
  input  logic [1:0]       cfg_mode,
  input  logic [XLEN-1:0]  cfg_expect,
  input  logic             clear,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_slot,
  output logic [4:0]       evt_rd,
  output logic [XLEN-1:0]  evt_data,
  output logic [CYC_W-1:0] evt_cycle,
  output logic             evt_mismatch,
  output logic [CNT_W-1:0] fifo_count,
  output logic [15:0]      overflow_cnt,
  output logic             mismatch_flag
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_LOG     = 2'b01,
    MODE_CMP     = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef struct packed {
    logic [IDX_W-1:0] slot;
    logic [4:0]       rd;
    logic [XLEN-1:0]  data;
    logic [CYC_W-1:0] cyc;
    logic             mis;
  } evt_t;

  // Slot configuration
  mode_e                mode_q   [NUM_WATCH];
  logic [4:0]           addr_q   [NUM_WATCH];
  logic [XLEN-1:0]      expect_q [NUM_WATCH];
  logic [NUM_WATCH-1:0] armed_q;

  // Event FIFO and status
  evt_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      ovf_q, ovf_d;
  logic             mis_flag_q, mis_flag_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  // Match results for the current cycle
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_mis;
  logic             hit_oneshot;
  logic             push, pop, full, accept, drop;
  evt_t             evt_in;
  evt_t             head;

  // Slot match: scan from the top so the lowest matching index is kept last.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    hit         = 1'b0;
    hit_idx     = '0;
    hit_mis     = 1'b0;
    hit_oneshot = 1'b0;
    for (int i = NUM_WATCH - 1; i >= 0; i--) begin
      if (wb_reg_write && (wb_rd_addr != 5'd0) && (mode_q[i] != MODE_OFF) &&
          (addr_q[i] == wb_rd_addr) &&
          ((mode_q[i] != MODE_ONESHOT) || armed_q[i])) begin
        hit         = 1'b1;
        hit_idx     = IDX_W'(i);
        hit_mis     = (mode_q[i] == MODE_CMP) && (wb_write_data != expect_q[i]);
        hit_oneshot = (mode_q[i] == MODE_ONESHOT);
      end
    end
  end

  assign evt_in = '{slot: hit_idx, rd: wb_rd_addr, data: wb_write_data,
                    cyc: cyc_q, mis: hit_mis};

  // Clear overrides both sides of the FIFO; a full FIFO accepts a push only
  // when the head leaves in the same cycle.
  assign push   = hit && !clear;
  assign pop    = evt_valid && evt_ready && !clear;
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Slot config writes, and disarming of one-shot slots after they fire.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        mode_q[i]   <= MODE_OFF;
        addr_q[i]   <= '0;
        expect_q[i] <= '0;
        armed_q[i]  <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          mode_q[i]   <= mode_e'(cfg_mode);
          addr_q[i]   <= cfg_addr;
          expect_q[i] <= cfg_expect;
          armed_q[i]  <= 1'b1;
        end else if (push && hit_oneshot && (hit_idx == IDX_W'(i))) begin
          armed_q[i]  <= 1'b0;
        end
      end
    end
  end

  // Next state of pointers, occupancy, status and the timestamp counter.
  always_comb begin
    cyc_d      = cyc_q + CYC_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    mis_flag_d = mis_flag_q;
    if (clear) begin
      cyc_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      ovf_d      = '0;
      mis_flag_d = 1'b0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      if (accept && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!accept && pop) cnt_d = cnt_q - CNT_W'(1);
      if (drop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
      if (push && hit_mis) mis_flag_d = 1'b1;
    end
  end

  // FIFO bookkeeping, status and cycle counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= '0;
      mis_flag_q <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      mis_flag_q <= mis_flag_d;
    end
  end

  // Event storage written at the tail.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Entries are only observed
    // through the occupancy count, so stale contents are never visible.
    if (accept) mem_q[wr_ptr_q] <= evt_in;
  end

  // Head of the FIFO, forced to zero while empty.
  assign head          = mem_q[rd_ptr_q];
  assign evt_valid     = (cnt_q != '0);
  assign evt_slot      = evt_valid ? head.slot : '0;
  assign evt_rd        = evt_valid ? head.rd   : '0;
  assign evt_data      = evt_valid ? head.data : '0;
  assign evt_cycle     = evt_valid ? head.cyc  : '0;
  assign evt_mismatch  = evt_valid && head.mis;
  assign fifo_count    = cnt_q;
  assign overflow_cnt  = ovf_q;
  assign mismatch_flag = mis_flag_q;

endmodule

// File: tb/tb_wb_watch_tracer.sv
// Self-checking bench for wb_watch_tracer. An event-queue reference model is
// stepped once per clock and compared against every output each cycle.
// Directed sequences and a vector table add constant expectations.
module tb_wb_watch_tracer;
  localparam int NW   = 4;
  localparam int DP   = 16;
  localparam int XL   = 32;
  localparam int CW   = 32;
  localparam int IW   = 2;
  localparam int CNTW = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wb_reg_write = 1'b0;
  logic [4:0]      wb_rd_addr = '0;
  logic [XL-1:0]   wb_write_data = '0;
  logic            cfg_we = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic [4:0]      cfg_addr = '0;
  logic [1:0]      cfg_mode = '0;
  logic [XL-1:0]   cfg_expect = '0;
  logic            clear = 1'b0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [IW-1:0]   evt_slot;
  logic [4:0]      evt_rd;
  logic [XL-1:0]   evt_data;
  logic [CW-1:0]   evt_cycle;
  logic            evt_mismatch;
  logic [CNTW-1:0] fifo_count;
  logic [15:0]     overflow_cnt;
  logic            mismatch_flag;

  always #5 clk = ~clk;

  wb_watch_tracer #(.NUM_WATCH(NW), .DEPTH(DP), .XLEN(XL), .CYC_W(CW)) dut (
    .clk(clk), .reset(reset),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_write_data(wb_write_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_expect(cfg_expect), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_slot(evt_slot), .evt_rd(evt_rd),
    .evt_data(evt_data), .evt_cycle(evt_cycle), .evt_mismatch(evt_mismatch),
    .fifo_count(fifo_count), .overflow_cnt(overflow_cnt), .mismatch_flag(mismatch_flag)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int            slot;
    int            rd;
    logic [XL-1:0] data;
    logic [CW-1:0] cyc;
    bit            mis;
  } ev_t;

  ev_t           mq[$];
  int            m_mode  [NW];
  int            m_addr  [NW];
  logic [XL-1:0] m_exp   [NW];
  bit            m_armed [NW];
  logic [CW-1:0] m_cyc;
  int            m_ovf;
  bit            m_misflag;

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < NW; i++) begin
      m_mode[i] = 0; m_addr[i] = 0; m_exp[i] = '0; m_armed[i] = 1'b1;
    end
    m_cyc = '0; m_ovf = 0; m_misflag = 1'b0;
  endfunction

  // One clock of the tracer, from the inputs present at the rising edge.
  function automatic void model_apply();
    int  found = -1;
    ev_t e;
    if (wb_reg_write && wb_rd_addr != 0)
      for (int i = 0; i < NW; i++)
        if (found < 0 && m_mode[i] != 0 && m_addr[i] == int'(wb_rd_addr) &&
            (m_mode[i] != 3 || m_armed[i]))
          found = i;
    if (clear) begin
      mq.delete(); m_ovf = 0; m_misflag = 1'b0; m_cyc = '0;
    end else begin
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      if (found >= 0) begin
        e.slot = found; e.rd = int'(wb_rd_addr); e.data = wb_write_data; e.cyc = m_cyc;
        e.mis  = (m_mode[found] == 2) && (wb_write_data != m_exp[found]);
        if (e.mis) m_misflag = 1'b1;
        if (mq.size() < DP) mq.push_back(e);
        else if (m_ovf < 65535) m_ovf++;
        if (m_mode[found] == 3) m_armed[found] = 1'b0;
      end
      m_cyc = m_cyc + 1;
    end
    if (cfg_we && int'(cfg_idx) < NW) begin
      m_mode[cfg_idx] = int'(cfg_mode); m_addr[cfg_idx] = int'(cfg_addr);
      m_exp[cfg_idx] = cfg_expect; m_armed[cfg_idx] = 1'b1;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("m.evt_valid", 64'(evt_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("m.evt_slot", 64'(evt_slot), 64'(mq[0].slot));
      check("m.evt_rd", 64'(evt_rd), 64'(mq[0].rd));
      check("m.evt_data", 64'(evt_data), 64'(mq[0].data));
      check("m.evt_cycle", 64'(evt_cycle), 64'(mq[0].cyc));
      check("m.evt_mismatch", 64'(evt_mismatch), 64'(mq[0].mis));
    end else begin
      check("m.evt_fields_zero", {evt_slot, evt_rd, evt_data, evt_cycle, evt_mismatch}, 64'd0);
    end
    check("m.fifo_count", 64'(fifo_count), 64'(mq.size()));
    check("m.overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
    check("m.mismatch_flag", 64'(mismatch_flag), 64'(m_misflag));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {evt_valid, evt_slot, evt_rd, evt_data, evt_cycle, evt_mismatch,
                 fifo_count, overflow_cnt, mismatch_flag}, 64'd0);
  endtask

  // Inputs change at the falling edge; the model follows the rising edge and
  // the outputs are compared at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_apply();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cfg(input int idx, input int addr, input int mode, input logic [XL-1:0] exp);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_addr = 5'(addr); cfg_mode = 2'(mode); cfg_expect = exp;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wb(input int rd, input logic [XL-1:0] data);
    wb_reg_write = 1'b1; wb_rd_addr = 5'(rd); wb_write_data = data;
    step();
    wb_reg_write = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            we;
    logic [4:0]    rd;
    logic [XL-1:0] data;
    bit            rdy;
    bit            e_valid;
    logic [4:0]    e_rd;
    logic [XL-1:0] e_data;
    bit            e_mis;
    int            e_cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 5'd6, 32'h14, 1'b0, 1'b1, 5'd6, 32'h14, 1'b0, 1};
    tbl[1] = '{1'b1, 5'd6, 32'h15, 1'b0, 1'b1, 5'd6, 32'h14, 1'b0, 2};
    tbl[2] = '{1'b1, 5'd0, 32'h99, 1'b0, 1'b1, 5'd6, 32'h14, 1'b0, 2};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd6, 32'h15, 1'b1, 1};
    tbl[4] = '{1'b1, 5'd5, 32'h7,  1'b1, 1'b1, 5'd5, 32'h7,  1'b0, 1};
    tbl[5] = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 0};

    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    reset = 1'b1;

    // Single logged write at cycle 7.
    clear = 1'b1; step(); clear = 1'b0;
    cfg(0, 5, 1, '0);
    repeat (6) step();
    wb(5, 32'h0000000A);
    check("s1.valid", 64'(evt_valid), 64'd1);
    check("s1.rd", 64'(evt_rd), 64'd5);
    check("s1.data", 64'(evt_data), 64'hA);
    check("s1.cycle", 64'(evt_cycle), 64'd7);
    check("s1.slot", 64'(evt_slot), 64'd0);
    check("s1.count", 64'(fifo_count), 64'd1);
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
    check("s1.pop_count", 64'(fifo_count), 64'd0);
    check("s1.pop_valid", 64'(evt_valid), 64'd0);

    // Compare mode, x0 write, and same-cycle pop+push, from the table.
    cfg(1, 6, 2, 32'h14);
    cfg(3, 0, 1, '0);
    for (int i = 0; i < 6; i++) begin
      wb_reg_write = tbl[i].we; wb_rd_addr = tbl[i].rd; wb_write_data = tbl[i].data;
      evt_ready = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d.valid", i), 64'(evt_valid), 64'(tbl[i].e_valid));
      check($sformatf("tbl%0d.rd", i), 64'(evt_rd), 64'(tbl[i].e_rd));
      check($sformatf("tbl%0d.data", i), 64'(evt_data), 64'(tbl[i].e_data));
      check($sformatf("tbl%0d.mis", i), 64'(evt_mismatch), 64'(tbl[i].e_mis));
      check($sformatf("tbl%0d.count", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
    end
    wb_reg_write = 1'b0; evt_ready = 1'b0;
    check("s2.mismatch_flag", 64'(mismatch_flag), 64'd1);

    // Priority and one-shot.
    cfg(1, 0, 0, '0);
    cfg(0, 7, 1, '0);
    cfg(2, 7, 3, '0);
    for (int k = 1; k <= 3; k++) wb(7, XL'(k));
    check("s3.count3", 64'(fifo_count), 64'd3);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("s3.slot%0d", k), 64'(evt_slot), 64'd0);
      check($sformatf("s3.data%0d", k), 64'(evt_data), 64'(k));
      evt_ready = 1'b1; step(); evt_ready = 1'b0;
    end
    cfg(0, 7, 0, '0);
    cfg(2, 7, 3, '0);
    wb(7, 32'd4);
    wb(7, 32'd5);
    check("s3.oneshot_count", 64'(fifo_count), 64'd1);
    check("s3.oneshot_slot", 64'(evt_slot), 64'd2);
    check("s3.oneshot_data", 64'(evt_data), 64'd4);
    check("s3.flag_sticky", 64'(mismatch_flag), 64'd1);
    evt_ready = 1'b1; step(); evt_ready = 1'b0;

    // Overflow, then push+pop while full.
    cfg(0, 9, 1, '0);
    clear = 1'b1; step(); clear = 1'b0;
    for (int k = 0; k < 20; k++) wb(9, XL'(100 + k));
    check("s4.count", 64'(fifo_count), 64'd16);
    check("s4.ovf", 64'(overflow_cnt), 64'd4);
    check("s4.head", 64'(evt_data), 64'd100);
    evt_ready = 1'b1; wb(9, 32'd200); evt_ready = 1'b0;
    check("s4.pp_count", 64'(fifo_count), 64'd16);
    check("s4.pp_ovf", 64'(overflow_cnt), 64'd4);
    check("s4.pp_head", 64'(evt_data), 64'd101);
    evt_ready = 1'b1; repeat (16) step(); evt_ready = 1'b0;
    check("s4.drained", 64'(fifo_count), 64'd0);

    // Retarget in the same cycle as a write to the old register.
    cfg(0, 5, 1, '0);
    cfg_we = 1'b1; cfg_idx = '0; cfg_addr = 5'd8; cfg_mode = 2'b01;
    wb(5, 32'h55);
    cfg_we = 1'b0;
    check("s5.old_count", 64'(fifo_count), 64'd1);
    check("s5.old_rd", 64'(evt_rd), 64'd5);
    wb(8, 32'h88);
    check("s5.new_count", 64'(fifo_count), 64'd2);
    evt_ready = 1'b1; repeat (2) step(); evt_ready = 1'b0;

    // Clear with a matching write in the same cycle.
    cfg(0, 5, 1, '0);
    for (int k = 1; k <= 3; k++) wb(5, XL'(k));
    check("s6.count3", 64'(fifo_count), 64'd3);
    clear = 1'b1; wb(5, 32'd4); clear = 1'b0;
    check("s6.count", 64'(fifo_count), 64'd0);
    check("s6.ovf", 64'(overflow_cnt), 64'd0);
    check("s6.flag", 64'(mismatch_flag), 64'd0);
    check("s6.valid", 64'(evt_valid), 64'd0);
    step();
    check("s6.still_empty", 64'(fifo_count), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int rsel[6];
      int pr;
      rsel = '{0, 3, 5, 6, 7, 8};
      pr = ((n / 200) % 3 == 0) ? 80 : (((n / 200) % 3 == 1) ? 25 : 0);
      wb_reg_write  = ($urandom_range(0, 3) != 0);
      wb_rd_addr    = 5'(rsel[$urandom_range(0, 5)]);
      wb_write_data = XL'($urandom_range(0, 3));
      evt_ready     = ($urandom_range(0, 99) < pr);
      clear         = ($urandom_range(0, 99) == 0);
      cfg_we        = ($urandom_range(0, 7) == 0);
      cfg_idx       = IW'($urandom_range(0, NW - 1));
      cfg_addr      = 5'(rsel[$urandom_range(0, 5)]);
      cfg_mode      = 2'($urandom_range(0, 3));
      cfg_expect    = XL'($urandom_range(0, 3));
      step();
    end
    wb_reg_write = 1'b0; evt_ready = 1'b0; clear = 1'b0; cfg_we = 1'b0;

    // Asynchronous reset in the middle of traffic.
    cfg(0, 5, 1, '0);
    wb(5, 32'd1);
    wb(5, 32'd2);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    wb(5, 32'd3);
    check("post_reset.valid", 64'(evt_valid), 64'd0);
    check("post_reset.count", 64'(fifo_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
